mem_buf_ctrl: RTL and testbench

Two-port controller that shares a single `memory_buffer` (16-bit, FIFO-ordered, no address, no status flags) between two requesters. It arbitrates round-robin, sequences the buffer's `w`/`r` strobes and `data_in`, and captures `data_out` back to the winning requester. It keeps its own occupancy count, so overflow and underflow are refused before they reach the buffer. It sits beside `memory_buffer` at the top level, and all buffer pins are driven only by this block.

---
 rtl/mem_buf_pkg.sv | 13 +
 rtl/mem_buf_rr_arb.sv | 10 +
 rtl/mem_buf_ctrl.sv | 104 ++++++++++
 tb/tb_mem_buf_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_buf_pkg.sv
// mem_buf_pkg: shared state encoding, op encoding and default sizes for the buffer controller.
package mem_buf_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_CAP  = 2'd2,
      RD_DONE = 2'd3
   } state_e;
   localparam logic OP_WRITE  = 1'b1;
   localparam logic OP_READ   = 1'b0;
   localparam int   DEF_WIDTH = 16;
   localparam int   DEF_DEPTH = 8;
endpackage

// File: rtl/mem_buf_rr_arb.sv
// mem_buf_rr_arb: combinational 2-way round-robin arbiter; the last-granted pointer lives in the caller.
module mem_buf_rr_arb (
   input  logic [1:0] req,
   input  logic       last,
   output logic       idx,
   output logic       valid
);
   assign valid = |req;
   assign idx   = (&req) ? ~last : req[1];
endmodule

// File: rtl/mem_buf_ctrl.sv
// mem_buf_ctrl: shares one FIFO memory_buffer between two requesters, arbitrating round-robin
// and refusing overflow/underflow from its own occupancy count.
module mem_buf_ctrl
   import mem_buf_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   output logic [1:0]       gnt,
   output logic             err,
   output logic [WIDTH-1:0] rdata,
   output logic [1:0]       rvalid,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             buf_w,
   output logic             buf_r,
   output logic [WIDTH-1:0] buf_din,
   input  logic [WIDTH-1:0] buf_dout
);
   state_e           state_q, state_d;
   logic             idx_q, op_q, last_q, full_q, empty_q;
   logic [WIDTH-1:0] wdata_q, rdata_q, din_q;
   logic [CW-1:0]    count_q, count_d;
   logic             arb_idx, arb_valid, refuse;

   mem_buf_rr_arb u_arb (
      .req   (req),
      .last  (last_q),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   assign refuse = (op_q == OP_WRITE) ? full_q : empty_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      gnt     = '0;
      rvalid  = '0;
      err     = 1'b0;
      buf_w   = 1'b0;
      buf_r   = 1'b0;
      case (state_q)
         IDLE:    state_d = arb_valid ? ISSUE : IDLE;
         ISSUE: begin
            gnt[idx_q] = 1'b1;
            err        = refuse;
            buf_w      = !refuse && op_q == OP_WRITE;
            buf_r      = !refuse && op_q == OP_READ;
            count_d    = buf_w ? count_q + CW'(1) : buf_r ? count_q - CW'(1) : count_q;
            state_d    = buf_r ? RD_CAP : IDLE;
         end
         RD_CAP:  state_d = RD_DONE;
         RD_DONE: begin
            rvalid[idx_q] = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 1'b0;
         op_q    <= OP_READ;
         wdata_q <= '0;
         last_q  <= 1'b1;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         rdata_q <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         full_q  <= count_d == CW'(DEPTH);
         empty_q <= count_d == '0;
         if (state_q == IDLE && arb_valid) begin
            idx_q   <= arb_idx;
            op_q    <= op[arb_idx];
            wdata_q <= arb_idx ? wdata1 : wdata0;
         end
         if (state_q == ISSUE) last_q <= idx_q;
         if (buf_w) din_q <= wdata_q;
         if (state_q == RD_CAP) rdata_q <= buf_dout;
      end
   end

   // buf_din only moves on an accepted write so the buffer pins stay quiet otherwise
   assign buf_din = buf_w ? wdata_q : din_q;
   assign rdata   = rdata_q;
   assign count   = count_q;
   assign full    = full_q;
   assign empty   = empty_q;
endmodule

// File: tb/tb_mem_buf_ctrl.sv
// tb_mem_buf_ctrl: randomized and directed traffic against a transaction-level model of the
// arbitrated FIFO; a monitor compares every grant and read return against the predicted queue.
module tb_mem_buf_ctrl;
   localparam int W = 16;
   localparam int D = 8;

   typedef struct {
      int         t;
      logic [1:0] g;
      logic       e, w, r;
      logic [W-1:0] d;
      int         c;
   } gexp_t;
   typedef struct {
      int           t;
      logic [1:0]   v;
      logic [W-1:0] d;
   } rexp_t;

   logic clk = 0, rst = 1;
   logic [1:0] req = 0, op = 0;
   logic [W-1:0] wdata0 = 0, wdata1 = 0;
   logic [1:0] gnt, rvalid;
   logic err, full, empty, buf_w, buf_r;
   logic [W-1:0] rdata, buf_din, buf_dout;
   logic [3:0] count;

   mem_buf_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .wdata0(wdata0), .wdata1(wdata1),
      .gnt(gnt), .err(err), .rdata(rdata), .rvalid(rvalid), .count(count),
      .full(full), .empty(empty), .buf_w(buf_w), .buf_r(buf_r),
      .buf_din(buf_din), .buf_dout(buf_dout)
   );

   always #5 clk = ~clk;

   int cyc = 0, pass = 0, total = 0, next_arb = 0;
   logic mlast = 1'b1;
   logic [W-1:0] mdin = '0;
   logic [W-1:0] mq[$], bq[$];
   gexp_t gq[$];
   rexp_t rq[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
   endtask

   // the memory_buffer itself: pops onto data_out at the edge that samples r
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bq.delete();
         buf_dout <= '0;
      end else begin
         if (buf_w) bq.push_back(buf_din);
         if (buf_r) buf_dout <= bq.size() != 0 ? bq.pop_front() : 16'hDEAD;
      end
   end

   // transaction model: one arbitration, then the controller is busy 2 (write/refused) or 4 (read) cycles
   always @(posedge clk) begin
      logic w, wr, bad;
      logic [W-1:0] d;
      gexp_t ge;
      rexp_t re;
      cyc++;
      if (rst) begin
         mq.delete(); gq.delete(); rq.delete();
         mlast = 1'b1; mdin = '0; next_arb = 0;
      end else if (cyc >= next_arb) begin
         if (req == 2'b00) next_arb = cyc + 1;
         else begin
            if (req[0] && req[1]) w = !mlast;
            else w = req[1];
            wr   = op[w];
            d    = w ? wdata1 : wdata0;
            bad  = wr ? mq.size() == D : mq.size() == 0;
            ge.t = cyc;
            ge.g = 2'b01 << w;
            ge.e = bad;
            ge.w = wr && !bad;
            ge.r = !wr && !bad;
            ge.c = mq.size();
            if (ge.w) mdin = d;
            ge.d = mdin;
            gq.push_back(ge);
            mlast = w;
            if (ge.w) mq.push_back(d);
            if (ge.r) begin
               re.t = cyc + 2;
               re.v = ge.g;
               re.d = mq.pop_front();
               rq.push_back(re);
            end
            next_arb = cyc + (ge.r ? 4 : 2);
         end
      end
   end

   always @(negedge clk) begin
      gexp_t e;
      rexp_t r;
      if (!rst) begin
         if (gq.size() != 0 && gq[0].t == cyc) begin
            e = gq.pop_front();
            chk("gnt", 32'(gnt), 32'(e.g));
            chk("err", 32'(err), 32'(e.e));
            chk("buf_w", 32'(buf_w), 32'(e.w));
            chk("buf_r", 32'(buf_r), 32'(e.r));
            chk("buf_din", 32'(buf_din), 32'(e.d));
            chk("count", 32'(count), 32'(e.c));
            chk("full", 32'(full), 32'(e.c == D));
            chk("empty", 32'(empty), 32'(e.c == 0));
         end else begin
            if (gq.size() != 0 && gq[0].t < cyc) begin
               chk("gnt_missed", 32'(cyc), 32'(gq[0].t));
               void'(gq.pop_front());
            end
            if (gnt != 0 || buf_w || buf_r) chk("spurious_gnt_strobe", 32'({gnt, buf_w, buf_r}), 32'(0));
         end
         if (rq.size() != 0 && rq[0].t == cyc) begin
            r = rq.pop_front();
            chk("rvalid", 32'(rvalid), 32'(r.v));
            chk("rdata", 32'(rdata), 32'(r.d));
         end else begin
            if (rq.size() != 0 && rq[0].t < cyc) begin
               chk("rvalid_missed", 32'(cyc), 32'(rq[0].t));
               void'(rq.pop_front());
            end
            if (rvalid != 0) chk("spurious_rvalid", 32'(rvalid), 32'(0));
         end
      end
   end

   task automatic do_req(input int i, input logic o, input logic [W-1:0] d);
      bit ok = 0;
      @(negedge clk);
      op[i] = o;
      if (i == 0) wdata0 = d; else wdata1 = d;
      req[i] = 1'b1;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = gnt[i];
      end
      req[i] = 1'b0;
      chk("gnt_timeout", 32'(ok), 32'(1));
   endtask

   task automatic rand_step(input int rate, input int wp, input bit en);
      for (int i = 0; i < 2; i++) begin
         if (req[i]) begin
            if (gnt[i]) req[i] = 1'b0;
         end else if (en && $urandom_range(99) < rate) begin
            op[i] = $urandom_range(99) < wp;
            if (i == 0) wdata0 = W'($urandom); else wdata1 = W'($urandom);
            req[i] = 1'b1;
         end
      end
   endtask

   task automatic run_rand(input int n, input int rate, input int wp);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rand_step(rate, wp, 1'b1);
      end
      for (int k = 0; k < 60 && req != 0; k++) begin
         @(negedge clk);
         rand_step(rate, wp, 1'b0);
      end
      chk("quiesce", 32'(req), 32'(0));
      repeat (6) @(negedge clk);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_count", 32'(count), 32'(0));
      chk("rst_empty", 32'(empty), 32'(1));
      chk("rst_full", 32'(full), 32'(0));
      chk("rst_outs", 32'({gnt, err, rvalid, buf_w, buf_r}), 32'(0));
      chk("rst_rdata", 32'(rdata), 32'(0));
      chk("rst_buf_din", 32'(buf_din), 32'(0));

      do_req(0, 1'b1, 16'hC005);
      @(negedge clk);
      chk("wr_count", 32'(count), 32'(1));
      chk("wr_empty", 32'(empty), 32'(0));
      do_req(1, 1'b0, '0);
      repeat (3) @(negedge clk);
      chk("rd_count", 32'(count), 32'(0));
      chk("rd_empty", 32'(empty), 32'(1));

      // both requesters write continuously until the buffer is full
      @(negedge clk);
      op = 2'b11; wdata0 = 16'h0001; wdata1 = 16'h0002; req = 2'b11;
      n = 0;
      for (int k = 0; k < 40 && n < D; k++) begin
         @(negedge clk);
         if (gnt != 0) n++;
      end
      req = 2'b00;
      chk("alt_grants", 32'(n), 32'(D));
      repeat (2) @(negedge clk);
      chk("fill_full", 32'(full), 32'(1));
      chk("fill_count", 32'(count), 32'(D));
      do_req(0, 1'b1, 16'hFFFF);
      repeat (2) @(negedge clk);
      chk("overflow_count", 32'(count), 32'(D));

      for (int k = 0; k <= D; k++) do_req(k % 2, 1'b0, '0);
      repeat (6) @(negedge clk);
      chk("drain_empty", 32'(empty), 32'(1));

      run_rand(300, 60, 80);
      run_rand(300, 60, 20);
      run_rand(400, 40, 50);

      // reset while a read sits in RD_CAP
      do_req(0, 1'b1, 16'hBEEF);
      repeat (2) @(negedge clk);
      do_req(1, 1'b0, '0);
      @(posedge clk);
      #1 rst = 1;
      #1;
      chk("midrst_outs", 32'({gnt, err, rvalid, buf_w, buf_r}), 32'(0));
      chk("midrst_count", 32'(count), 32'(0));
      chk("midrst_empty", 32'(empty), 32'(1));
      chk("midrst_rdata", 32'(rdata), 32'(0));
      chk("midrst_buf_din", 32'(buf_din), 32'(0));
      repeat (2) @(posedge clk);
      #1 rst = 0;
      repeat (10) @(negedge clk);
      chk("post_rst_count", 32'(count), 32'(0));

      run_rand(300, 50, 50);
      repeat (8) @(negedge clk);
      chk("gq_left", 32'(gq.size()), 32'(0));
      chk("rq_left", 32'(rq.size()), 32'(0));
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
